bsg_mesh_router_wormhole_output_arb: RTL and testbench

Per-output-port arbiter for the mesh router. It sits after the per-input DOR decoders and in front of one output link. It takes the decoded request bit for this port from each input and grants the output to one input at a time, round-robin. The grant is held for a whole wormhole packet (head plus body flits), and the block drives the crossbar select and the input dequeue (yumi) signals.

---
 rtl/bsg_mesh_router_wormhole_output_arb.sv | 75 +++++++
 tb/tb_bsg_mesh_router_wormhole_output_arb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bsg_mesh_router_wormhole_output_arb.sv
// bsg_mesh_router_wormhole_output_arb: round-robin output arbiter holding grant for a whole wormhole packet
// Optional stall counter output enabled by BSG_MESH_ROUTER_ARB_STALL_CNT_EN.
module bsg_mesh_router_wormhole_output_arb #(
  parameter int dirs_p = 5,
  parameter int len_width_p = 4,
  localparam int ptr_w = dirs_p > 1 ? $clog2(dirs_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [dirs_p-1:0]             req_i,
  input  logic [dirs_p-1:0]             v_i,
  input  logic [dirs_p*len_width_p-1:0] len_i,
  input  logic                          ready_i,
  output logic                          v_o,
  output logic [dirs_p-1:0]             sel_o,
  output logic [dirs_p-1:0]             yumi_o,
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
  output logic [15:0]                   stall_cnt_o,
`endif
  output logic                          busy_o
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_r;
  logic [dirs_p-1:0] owner_r;
  logic [len_width_p-1:0] count_r, win_len;
  logic [ptr_w-1:0] rr_ptr_r, win;
  logic found, busy, xfer;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < dirs_p; k++) begin
      int j;
      j = int'(rr_ptr_r) + k;
      j = j >= dirs_p ? j - dirs_p : j;
      if (!found && req_i[j]) begin
        found = 1'b1;
        win = ptr_w'(j);
      end
    end
  end
  assign win_len = len_i[win*len_width_p +: len_width_p];
  assign busy = state_r == BUSY;
  assign sel_o = reset_i ? '0 : busy ? owner_r : found ? dirs_p'(1) << win : '0;
  assign v_o = reset_i ? 1'b0 : busy ? |(v_i & owner_r) : found;
  assign yumi_o = sel_o & {dirs_p{v_o & ready_i}};
  assign busy_o = !reset_i && busy;
  assign xfer = v_o & ready_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      owner_r <= '0;
      count_r <= '0;
      rr_ptr_r <= '0;
    end else if (xfer && !busy) begin
      rr_ptr_r <= win == ptr_w'(dirs_p - 1) ? '0 : win + ptr_w'(1);
      if (win_len != '0) begin
        state_r <= BUSY;
        owner_r <= dirs_p'(1) << win;
        count_r <= win_len;
      end
    end else if (xfer) begin
      count_r <= count_r - len_width_p'(1);
      if (count_r == len_width_p'(1)) begin
        state_r <= IDLE;
        owner_r <= '0;
      end
    end
  end
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) stall_cnt_o <= '0;
    else if (v_o && !ready_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_bsg_mesh_router_wormhole_output_arb.sv
// tb_bsg_mesh_router_wormhole_output_arb: scoreboard bench with directed scenarios and random traffic
module tb_bsg_mesh_router_wormhole_output_arb;
  logic clk = 1'b0, reset_i = 1'b1, ready_i = 1'b0, v_o, busy_o;
  logic [4:0] req_i = '0, v_i = '0, sel_o, yumi_o;
  logic [19:0] len_i = '0;
  logic [15:0] stall_cnt;
  typedef struct {logic v; logic [4:0] sel; logic [4:0] yumi; logic busy; logic [15:0] stall;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int m_owner = -1, m_left = 0, m_prio = 0, m_stall = 0;
  always #5 clk = ~clk;
  bsg_mesh_router_wormhole_output_arb dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .v_i(v_i), .len_i(len_i), .ready_i(ready_i),
    .v_o(v_o), .sel_o(sel_o), .yumi_o(yumi_o),
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
    .stall_cnt_o(stall_cnt),
`endif
    .busy_o(busy_o)
  );
`ifndef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
  assign stall_cnt = '0;
`endif
  task automatic step(input logic rst, input logic [4:0] req, input logic [4:0] v, input int l0, input int l1,
                      input int l2, input int l3, input int l4, input logic rdy);
    exp_t e;
    int la[5];
    int w;
    la = '{l0, l1, l2, l3, l4};
    @(posedge clk);
    #1;
    reset_i = rst; req_i = req; v_i = v; ready_i = rdy;
    for (int i = 0; i < 5; i++) len_i[i*4 +: 4] = 4'(la[i]);
    e = '{1'b0, 5'd0, 5'd0, 1'b0, 16'(m_stall)};
    w = -1;
    if (!rst && m_owner >= 0) begin
      e.sel[m_owner] = 1'b1;
      e.v = v[m_owner];
      e.busy = 1'b1;
    end else if (!rst) begin
      for (int k = 0; k < 5; k++) if (w < 0 && req[(m_prio + k) % 5]) w = (m_prio + k) % 5;
      if (w >= 0) begin
        e.sel[w] = 1'b1;
        e.v = 1'b1;
      end
    end
    if (e.v && rdy) e.yumi = e.sel;
    exp_q.push_back(e);
    if (rst) begin
      m_owner = -1; m_left = 0; m_prio = 0; m_stall = 0;
    end else begin
      if (e.v && !rdy && m_stall < 65535) m_stall++;
      if (e.v && rdy && m_owner < 0) begin
        m_prio = (w + 1) % 5;
        if (la[w] > 0) begin
          m_owner = w;
          m_left = la[w];
        end
      end else if (e.v && rdy) begin
        m_left--;
        if (m_left == 0) m_owner = -1;
      end
    end
  endtask
  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("v_o", int'(v_o), int'(e.v));
      cmp("sel_o", int'(sel_o), int'(e.sel));
      cmp("yumi_o", int'(yumi_o), int'(e.yumi));
      cmp("busy_o", int'(busy_o), int'(e.busy));
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
      cmp("stall_cnt_o", int'(stall_cnt), int'(e.stall));
`endif
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'b00100, 5'b00100, 0, 0, 0, 0, 0, 1);
    step(0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 5'b11111, 5'b11111, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5'b00010, 5'b11111, 0, 3, 0, 0, 0, 1);
    repeat (4) step(0, 5'b01000, 5'b11111, 0, 0, 0, 0, 0, 1);
    step(0, 5'b00100, 5'b00100, 0, 0, 3, 0, 0, 1);
    step(0, 5'b00000, 5'b00100, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 5'b00001, 5'b00100, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 5'b00001, 5'b00001, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 5'b00001, 5'b00101, 0, 0, 0, 0, 0, 1);
    step(0, 5'b10000, 5'b10000, 0, 0, 0, 0, 7, 1);
    repeat (2) step(0, 5'b00000, 5'b10000, 0, 0, 0, 0, 0, 1);
    step(1, 5'b10001, 5'b10001, 0, 0, 0, 0, 0, 1);
    step(0, 5'b10001, 5'b10001, 0, 0, 0, 0, 0, 1);
    step(0, 5'b00010, 5'b00010, 0, 15, 0, 0, 0, 1);
    repeat (16) step(0, 5'b00000, 5'b00010, 0, 0, 0, 0, 0, 1);
`ifdef BSG_MESH_ROUTER_ARB_STALL_CNT_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) step(0, 5'b00001, 5'b00001, 0, 0, 0, 0, 0, 0);
    repeat (70000) step(0, 5'b00001, 5'b00001, 0, 0, 0, 0, 0, 0);
`endif
    repeat (2000) begin
      logic [4:0] v;
      v = 5'($urandom);
      step($urandom_range(49) == 0, v & 5'($urandom), v,
           $urandom_range(3) == 0 ? 0 : $urandom_range(15), $urandom_range(3),
           $urandom_range(1) * $urandom_range(15), $urandom_range(2), $urandom_range(15),
           $urandom_range(3) != 0);
    end
    repeat (3) @(negedge clk);
    cmp("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
